// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the multi-port register file and its busy scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_RD   = 2;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per register plus a registered count of set flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic                 i_claim_en,
  input  logic [ADDR_W-1:0]    i_claim_addr,
  output logic [2**ADDR_W-1:0] o_busy,
  output logic [ADDR_W:0]      o_busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_busy_cnt;
  logic [DEPTH-1:0] w_busy_next;
  logic             w_wr_valid;
  logic             w_claim_valid;
  logic             w_set_new;
  logic             w_clear_busy;

  assign w_wr_valid    = i_wr_en && (i_wr_addr != '0);
  assign w_claim_valid = i_claim_en && (i_claim_addr != '0);

  // Count moves only on real transitions; a claim colliding with a write to the same register keeps it busy.
  assign w_set_new    = w_claim_valid && !r_busy[i_claim_addr];
  assign w_clear_busy = w_wr_valid && r_busy[i_wr_addr] &&
                        !(w_claim_valid && (i_claim_addr == i_wr_addr));

  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_valid) begin
      w_busy_next[i_wr_addr] = 1'b0;
    end
    if (w_claim_valid) begin
      w_busy_next[i_claim_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy <= w_busy_next;
      case ({w_set_new, w_clear_busy})
        2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
        2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
        default: r_busy_cnt <= r_busy_cnt;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, combinational reads and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy state) to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = DEF_N_RD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_valid;

  assign w_wr_valid = wr_en && (wr_addr != '0);

`ifdef REGFILE_BYPASS_EN
  logic w_claim_valid;
  assign w_claim_valid = claim_en && (claim_addr != '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_claim_en  (claim_en),
    .i_claim_addr(claim_addr),
    .o_busy      (w_busy),
    .o_busy_cnt  (busy_cnt)
  );

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_busy_bit;

    assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];

    // Address 0 is forced to zero so it is clean even before the first reset.
    always_comb begin
      w_data     = (w_addr == '0) ? '0 : r_regs[w_addr];
      w_busy_bit = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_valid && (w_addr == wr_addr)) begin
        w_data     = wr_data;
        w_busy_bit = w_claim_valid && (claim_addr == w_addr);
      end
`endif
    end

    assign rd_data[g*DATA_W +: DATA_W] = w_data;
    assign rd_busy[g]                  = w_busy_bit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a behavioural model predicts every cycle's read view and busy count.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              claim_en;
  logic [AW-1:0]     claim_addr;
  logic [AW:0]       busy_cnt;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .N_RD  (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .claim_en  (claim_en),
    .claim_addr(claim_addr),
    .busy_cnt  (busy_cnt)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  r0;
    logic [4:0]  r1;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mReg [DEPTH];
  logic        mBusy[DEPTH];
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic vec_t mkVec(input logic r, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic ce, input logic [4:0] ca,
                                 input logic [4:0] r0, input logic [4:0] r1);
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.wd = wd;
    v.ce = ce; v.ca = ca; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  // Expected combinational view for this cycle, taken from the model before the coming edge.
  function automatic exp_t predict(input vec_t v, input string tag);
    exp_t        e;
    logic [4:0]  ra[2];
    logic [31:0] d;
    logic        b;
    int          c;
    ra[0] = v.r0;
    ra[1] = v.r1;
    e.tag = tag;
    for (int p = 0; p < 2; p++) begin
      d = (ra[p] == 5'd0) ? 32'd0 : mReg[ra[p]];
      b = mBusy[ra[p]];
`ifdef REGFILE_BYPASS_EN
      if (v.we && (v.wa != 5'd0) && (v.wa == ra[p])) begin
        d = v.wd;
        b = v.ce && (v.ca == ra[p]);
      end
`endif
      if (p == 0) e.d0 = d;
      else        e.d1 = d;
      e.b[p] = b;
    end
    c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(mBusy[i]);
    e.cnt = 6'(c);
    return e;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    rst        = v.rst;
    wr_en      = v.we;
    wr_addr    = v.wa;
    wr_data    = v.wd;
    claim_en   = v.ce;
    claim_addr = v.ca;
    rd_addr    = {v.r1, v.r0};
    sbq.push_back(predict(v, tag));
  endtask

  // Clock edge: update the model with what the DUT saw, then leave #1 of margin.
  task automatic advance(input vec_t v);
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mReg[i]  = 32'd0;
        mBusy[i] = 1'b0;
      end
    end else begin
      if (v.we && (v.wa != 5'd0)) begin
        mReg[v.wa]  = v.wd;
        mBusy[v.wa] = 1'b0;
      end
      if (v.ce && (v.ca != 5'd0)) mBusy[v.ca] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    vec_t v[$];
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd31));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0));
    for (int i = 0; i < 8; i++) begin
      v.push_back(mkVec(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))));
    end
    v.push_back(mkVec(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4));
    for (int a = 0; a < DEPTH; a += 2) begin
      v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(a + 1)));
    end
    foreach (v[i]) begin
      exp_t e;
      applyStimulus(v[i], $sformatf("reset[%0d]", i));
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if ({rd_data, rd_busy, busy_cnt} !== {e.d1, e.d0, e.b, e.cnt}) begin
        miscompares++;
        $display("[TB] FAIL %s: got data=%h/%h busy=%b cnt=%0d, want data=%h/%h busy=%b cnt=%0d",
                 e.tag, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, e.d0, e.d1, e.b, e.cnt);
      end
      advance(v[i]);
    end
  endtask

  task automatic test_write_read();
    vec_t v[$];
    v.push_back(mkVec(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd5));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 5'd5,  5'd5));
    v.push_back(mkVec(1'b0, 1'b1, 5'd0,  32'h1,        1'b0, 5'd0, 5'd0,  5'd5));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 5'd0,  5'd0));
    v.push_back(mkVec(1'b0, 1'b1, 5'd12, 32'h0BADF00D, 1'b0, 5'd0, 5'd5,  5'd12));
    v.push_back(mkVec(1'b0, 1'b1, 5'd31, 32'h80000001, 1'b0, 5'd0, 5'd12, 5'd5));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 5'd31, 5'd12));
    foreach (v[i]) begin
      exp_t e;
      applyStimulus(v[i], $sformatf("write_read[%0d]", i));
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if ({rd_data, rd_busy, busy_cnt} !== {e.d1, e.d0, e.b, e.cnt}) begin
        miscompares++;
        $display("[TB] FAIL %s: got data=%h/%h busy=%b cnt=%0d, want data=%h/%h busy=%b cnt=%0d",
                 e.tag, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, e.d0, e.d1, e.b, e.cnt);
      end
      advance(v[i]);
    end
  endtask

  task automatic test_claim_release();
    vec_t v[$];
    v.push_back(mkVec(1'b0, 1'b0, 5'd0,  32'd0,   1'b1, 5'd7,  5'd7,  5'd7));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  5'd7,  5'd7));
    v.push_back(mkVec(1'b0, 1'b1, 5'd7,  32'h12,  1'b0, 5'd0,  5'd7,  5'd6));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  5'd7,  5'd7));
    v.push_back(mkVec(1'b0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 5'd20, 5'd7));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  5'd20, 5'd7));
    foreach (v[i]) begin
      exp_t e;
      applyStimulus(v[i], $sformatf("claim_release[%0d]", i));
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if ({rd_data, rd_busy, busy_cnt} !== {e.d1, e.d0, e.b, e.cnt}) begin
        miscompares++;
        $display("[TB] FAIL %s: got data=%h/%h busy=%b cnt=%0d, want data=%h/%h busy=%b cnt=%0d",
                 e.tag, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, e.d0, e.d1, e.b, e.cnt);
      end
      advance(v[i]);
    end
  endtask

  task automatic test_claim_write_same();
    vec_t v[$];
    v.push_back(mkVec(1'b0, 1'b1, 5'd9, 32'h34, 1'b1, 5'd9,  5'd9,  5'd9));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd9,  5'd9));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 5'd9,  5'd9,  5'd0));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd9,  5'd10));
    v.push_back(mkVec(1'b0, 1'b1, 5'd9, 32'h56, 1'b1, 5'd10, 5'd9,  5'd10));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd9,  5'd10));
    v.push_back(mkVec(1'b0, 1'b1, 5'd10, 32'h78, 1'b0, 5'd0, 5'd10, 5'd9));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd10, 5'd9));
    foreach (v[i]) begin
      exp_t e;
      applyStimulus(v[i], $sformatf("claim_write_same[%0d]", i));
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if ({rd_data, rd_busy, busy_cnt} !== {e.d1, e.d0, e.b, e.cnt}) begin
        miscompares++;
        $display("[TB] FAIL %s: got data=%h/%h busy=%b cnt=%0d, want data=%h/%h busy=%b cnt=%0d",
                 e.tag, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, e.d0, e.d1, e.b, e.cnt);
      end
      advance(v[i]);
    end
  endtask

  task automatic test_claim_all();
    vec_t v[$];
    for (int a = 1; a < DEPTH; a++) begin
      v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(a), 5'(a - 1)));
    end
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd31));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd1));
    for (int a = 1; a < DEPTH; a++) begin
      v.push_back(mkVec(1'b0, 1'b1, 5'(a), 32'(a) * 32'h01010101, 1'b0, 5'd0, 5'(a), 5'd31));
    end
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd31, 5'd16));
    v.push_back(mkVec(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 5'd1));
    foreach (v[i]) begin
      exp_t e;
      applyStimulus(v[i], $sformatf("claim_all[%0d]", i));
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if ({rd_data, rd_busy, busy_cnt} !== {e.d1, e.d0, e.b, e.cnt}) begin
        miscompares++;
        $display("[TB] FAIL %s: got data=%h/%h busy=%b cnt=%0d, want data=%h/%h busy=%b cnt=%0d",
                 e.tag, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, e.d0, e.d1, e.b, e.cnt);
      end
      advance(v[i]);
    end
  endtask

  task automatic test_bypass();
    vec_t v[$];
    v.push_back(mkVec(1'b0, 1'b1, 5'd3, 32'h11,       1'b0, 5'd0, 5'd3, 5'd4));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd3, 5'd3));
    v.push_back(mkVec(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd4));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd3, 5'd3));
    v.push_back(mkVec(1'b0, 1'b1, 5'd3, 32'h5A5A5A5A, 1'b1, 5'd3, 5'd3, 5'd3));
    v.push_back(mkVec(1'b0, 1'b1, 5'd3, 32'h77,       1'b0, 5'd0, 5'd4, 5'd3));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd3, 5'd3));
    foreach (v[i]) begin
      exp_t e;
      applyStimulus(v[i], $sformatf("bypass[%0d]", i));
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if ({rd_data, rd_busy, busy_cnt} !== {e.d1, e.d0, e.b, e.cnt}) begin
        miscompares++;
        $display("[TB] FAIL %s: got data=%h/%h busy=%b cnt=%0d, want data=%h/%h busy=%b cnt=%0d",
                 e.tag, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, e.d0, e.d1, e.b, e.cnt);
      end
      advance(v[i]);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    for (int i = 0; i < 60; i++) begin
      v.push_back(mkVec(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                        5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))));
    end
    v.push_back(mkVec(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2));
    v.push_back(mkVec(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2));
    foreach (v[i]) begin
      exp_t e;
      applyStimulus(v[i], $sformatf("back_to_back[%0d]", i));
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if ({rd_data, rd_busy, busy_cnt} !== {e.d1, e.d0, e.b, e.cnt}) begin
        miscompares++;
        $display("[TB] FAIL %s: got data=%h/%h busy=%b cnt=%0d, want data=%h/%h busy=%b cnt=%0d",
                 e.tag, rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, e.d0, e.d1, e.b, e.cnt);
      end
      advance(v[i]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
    rd_addr    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mReg[i]  = 32'd0;
      mBusy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_claim_release();
    test_claim_write_same();
    test_claim_all();
    test_bypass();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter N_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port rd_addr  input  N_RD*ADDR_W  packed read addresses; port i occupies slice i.
REQ-007 Port rd_data  output  N_RD*DATA_W  packed read data; port i occupies slice i.
REQ-008 Port rd_busy  output  N_RD  port i register has a pending (not yet written) producer.
REQ-009 Port wr_en, wr_addr, wr_data  input  1, ADDR_W, DATA_W  write request, address and data.
REQ-010 Port claim_en, claim_addr  input  1, ADDR_W  marks a register busy (producer issued).
REQ-011 Port busy_cnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-012 Register 0 SHALL read as 0 always; writes and claims to address 0 SHALL be ignored.
REQ-013 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]] in the same cycle, zero read latency.
REQ-014 A write with wr_en=1, wr_addr!=0 SHALL update reg[wr_addr] at the next clk edge, one-cycle write latency.
REQ-015 A write SHALL clear busy[wr_addr] at the same edge.
REQ-016 A claim with claim_en=1, claim_addr!=0 SHALL set busy[claim_addr] at the next edge.
REQ-017 A write and a claim in the same cycle to the same address SHALL leave busy set (claim wins); data is still written.
REQ-018 A claim to an already-busy register SHALL leave it busy with no change in busy_cnt.
REQ-019 A write to a non-busy register SHALL update data and leave busy_cnt unchanged.
REQ-020 busy_cnt SHALL be registered, track popcount(busy) exactly, and change by -1, 0 or +1 per cycle; it SHALL never wrap (range 0..2**ADDR_W-1).
REQ-021 rd_busy[i] SHALL reflect the busy bit as registered, with no same-cycle look-ahead of claim or write (bypass excepted, REQ-025).
REQ-022 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-023 While rst=1 at a clk edge, all registers SHALL clear to 0, all busy bits to 0 and busy_cnt to 0; write and claim in that cycle SHALL be ignored.
REQ-024 After reset, rd_data SHALL be 0 and rd_busy SHALL be 0 for every port until a write or claim completes; rst asserted mid-operation SHALL discard all pending state.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN: when defined, a read port whose address equals a same-cycle valid write (wr_en=1, wr_addr!=0) SHALL return wr_data and rd_busy=0 combinationally, unless a same-cycle claim targets that address, in which case rd_busy=1; when undefined, reads SHALL return stored contents only (new value visible the cycle after the write).

Structure
REQ-026 A shared package regfile_pkg SHALL hold default DATA_W/ADDR_W/N_RD constants and the register-address typedef.
REQ-027 Busy bits and busy_cnt SHALL live in sub-module regfile_scoreboard; the data array and read muxing in regfile_mp.

Verification
REQ-028 Reset: rst=1 one cycle after random writes -> all rd_data=0, rd_busy=0, busy_cnt=0.
REQ-029 Write reg 5 = 0xDEADBEEF, read ports 0 and 1 at 5 -> both 0xDEADBEEF the next cycle (same cycle with bypass); write to reg 0 = 0x1 -> reads 0.
REQ-030 Claim reg 7 -> rd_busy=1, busy_cnt=1; write reg 7 = 0x12 -> rd_busy=0, busy_cnt=0, data 0x12.
REQ-031 Same cycle claim 9 and write 9 = 0x34 -> data 0x34, busy stays 1, busy_cnt=1; double claim of 9 -> busy_cnt stays 1.
REQ-032 Claim all 31 nonzero registers -> busy_cnt=31; claim reg 0 -> no change; release all -> busy_cnt=0, no wrap.
REQ-033 Bypass build: write reg 3 = 0xA5A5A5A5 while reading 3 -> same-cycle rd_data=0xA5A5A5A5; non-bypass build -> old value that cycle.
